// File: rtl/hpf_switch_ctrl.sv
// Click-free highpass cutoff switching: debounce the panel request, fade the biquad
// output to silence, swap coefficients, flush the biquad history, fade back in.
module hpf_switch_ctrl #(
   parameter int DEBOUNCE  = 1024,
   parameter int RAMP_LOG2 = 6,
   parameter int FLUSH_SMP = 8
) (
   input  logic               clk_144,
   input  logic               reset_n,
   input  logic               sample_tick,
   input  logic [2:0]         filter_req,
   input  logic signed [15:0] audio_in,
   output logic signed [15:0] hp_in,
   output logic [2:0]         filter,
   input  logic signed [15:0] hp_out,
   output logic signed [15:0] audio_out,
   output logic               busy,
   output logic [2:0]         dbg_state
);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int GW = RAMP_LOG2 + 1;
   localparam int FW = $clog2(FLUSH_SMP + 1);
   localparam int PW = 16 + GW + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
   localparam logic [GW-1:0] FULL    = {1'b1, {RAMP_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      FADE_OUT = 3'd1,
      SWITCH   = 3'd2,
      FLUSH    = 3'd3,
      FADE_IN  = 3'd4
   } state_t;

   state_t              state_q;
   logic [2:0]          req_d, req_q, target_q, filter_q;
   logic [CW-1:0]       cnt_q;
   logic [GW-1:0]       gain_d, gain_q;
   logic [FW-1:0]       flush_q;
   logic signed [15:0]  audio_out_q;
   logic signed [PW-1:0] prod;
   logic                retarget;

   // Debounce: a mapped request must hold DEBOUNCE cycles past its first sighting.
   assign req_d = (filter_req > 3'd4) ? 3'd0 : filter_req;

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         req_q    <= 3'd0;
         cnt_q    <= '0;
         target_q <= 3'd0;
      end else begin
         req_q <= req_d;
         if (req_d != req_q) begin
            cnt_q <= '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (cnt_q == CNT_MAX && req_d == req_q) begin
            target_q <= req_q;
         end
      end
   end

   assign retarget = (target_q != filter_q);

   // A ramp step is taken only on a tick, and never on a cycle that reverses direction.
   always_comb begin
      gain_d = gain_q;
      if (sample_tick) begin
         if (state_q == FADE_OUT && retarget && gain_q != '0) begin
            gain_d = gain_q - 1'b1;
         end else if (state_q == FADE_IN && !retarget && gain_q != FULL) begin
            gain_d = gain_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FADE_IN;
         gain_q   <= '0;
         filter_q <= 3'd0;
         flush_q  <= '0;
      end else begin
         gain_q <= gain_d;
         case (state_q)
            RUN: begin
               if (retarget) state_q <= FADE_OUT;
            end
            FADE_OUT: begin
               if (!retarget) begin
                  state_q <= FADE_IN;
               end else if (sample_tick && gain_d == '0) begin
                  state_q <= SWITCH;
               end
            end
            SWITCH: begin
               filter_q <= target_q;
               flush_q  <= FW'(FLUSH_SMP);
               state_q  <= FLUSH;
            end
            FLUSH: begin
               if (sample_tick) begin
                  flush_q <= flush_q - 1'b1;
                  if (flush_q <= FW'(1)) state_q <= FADE_IN;
               end
            end
            FADE_IN: begin
               if (retarget) begin
                  state_q <= FADE_OUT;
               end else if (gain_d == FULL) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= FADE_IN;
         endcase
      end
   end

   // Scale by the gain that applies after this tick's ramp step, so full gain is exact.
   assign prod = PW'(hp_out) * PW'($signed({1'b0, gain_d}));

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         audio_out_q <= '0;
      end else if (sample_tick) begin
         audio_out_q <= 16'(prod >>> RAMP_LOG2);
      end
   end

   assign hp_in     = (state_q == FLUSH) ? 16'sd0 : audio_in;
   assign filter    = filter_q;
   assign audio_out = audio_out_q;
   assign busy      = (state_q != RUN);
   assign dbg_state = state_q;

endmodule
